// File: rtl/pwm_dec_pkg.sv
// Shared constants and state encoding for the RGB PWM duty decoder.
package pwm_dec_pkg;

  localparam int unsigned NUM_CH             = 3;
  localparam int unsigned DEFAULT_CNT_W      = 13;
  localparam int unsigned DEFAULT_MAX_PERIOD = 8191;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_STUCK   = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StMeasure = ST_MEASURE,
    StStuck   = ST_STUCK
  } dec_state_e;

endpackage

// File: rtl/pwm_channel_decoder.sv
// One PWM line: synchroniser, turn-on edge detect, period/on-time counters and report FSM.
module pwm_channel_decoder
  import pwm_dec_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned MAX_PERIOD  = DEFAULT_MAX_PERIOD,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] on_time_o,
  output logic             stuck_o,
  output logic             stuck_level_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line_on;
  logic                   on_edge;
  logic                   at_max;

  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] on_time_q, on_time_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  assign line_on = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
  assign on_edge = line_on & ~prev_q;
  assign at_max  = (per_cnt_q == MAX_CNT);

  // Sync chain resets to the off level so reset release never looks like a turn-on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q <= line_on;
    end
  end

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    on_cnt_d      = on_cnt_q;
    valid_d       = 1'b0;
    period_d      = period_q;
    on_time_d     = on_time_q;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    unique case (state_q)
      StIdle, StMeasure: begin
        if (on_edge) begin
          if (state_q == StMeasure) begin
            valid_d       = 1'b1;
            period_d      = per_cnt_q;
            on_time_d     = on_cnt_q;
            stuck_d       = 1'b0;
            stuck_level_d = 1'b0;
          end
          state_d   = StMeasure;
          per_cnt_d = ONE_CNT;
          on_cnt_d  = ONE_CNT;
        end else if (at_max) begin
          // Counters stop here, so they can never wrap.
          valid_d       = 1'b1;
          period_d      = MAX_CNT;
          on_time_d     = line_on ? MAX_CNT : '0;
          stuck_d       = 1'b1;
          stuck_level_d = line_on;
          state_d       = StStuck;
        end else begin
          per_cnt_d = per_cnt_q + ONE_CNT;
          if (line_on) begin
            on_cnt_d = on_cnt_q + ONE_CNT;
          end
        end
      end
      StStuck: begin
        if (on_edge) begin
          state_d   = StMeasure;
          per_cnt_d = ONE_CNT;
          on_cnt_d  = ONE_CNT;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      per_cnt_q     <= '0;
      on_cnt_q      <= '0;
      valid_q       <= 1'b0;
      period_q      <= '0;
      on_time_q     <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      on_cnt_q      <= on_cnt_d;
      valid_q       <= valid_d;
      period_q      <= period_d;
      on_time_q     <= on_time_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign valid_o       = valid_q;
  assign period_o      = period_q;
  assign on_time_o     = on_time_q;
  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_level_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Three-channel PWM capture: one decoder per R/G/B line, outputs packed per channel.
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned MAX_PERIOD  = DEFAULT_MAX_PERIOD,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       pwm_n,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] on_time,
  output logic [NUM_CH-1:0]       stuck,
  output logic [NUM_CH-1:0]       stuck_level
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel_decoder #(
      .CNT_W      (CNT_W),
      .MAX_PERIOD (MAX_PERIOD),
      .SYNC_STAGES(SYNC_STAGES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_i        (pwm_n[i]),
      .valid_o      (valid[i]),
      .period_o     (period[i*CNT_W +: CNT_W]),
      .on_time_o    (on_time[i*CNT_W +: CNT_W]),
      .stuck_o      (stuck[i]),
      .stuck_level_o(stuck_level[i])
    );
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: directed scenarios plus random PWM against a timestamp model.
module tb_pwm_duty_decoder;

  localparam int unsigned CW   = 13;
  localparam int unsigned MAXP = 8191;
  localparam int unsigned SS   = 2;
  localparam bit          AL   = 1'b1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      pwm_n = 3'b111;
  logic [2:0]      valid;
  logic [3*CW-1:0] period;
  logic [3*CW-1:0] on_time;
  logic [2:0]      stuck;
  logic [2:0]      stuck_level;

  pwm_duty_decoder #(
    .CNT_W      (CW),
    .MAX_PERIOD (MAXP),
    .SYNC_STAGES(SS),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_n      (pwm_n),
    .valid      (valid),
    .period     (period),
    .on_time    (on_time),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
    int per;
    int ont;
    bit stk;
    bit lvl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rel = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int ch);
    checks++;
    failures++;
    $display("FAIL %s: channel %0d at cycle %0d", name, ch, cyc);
  endtask

  // ---------------- reference model: timestamps of turn-on edges ----------------
  bit pin_log [3][131072];
  bit m_meas[3];
  bit m_stuck[3];
  int m_ref[3];

  // Line level as the decoder sees it at edge j: pin sampled SS edges earlier, off before reset release.
  function automatic bit on_at(input int c, input int j);
    if (j - int'(SS) >= rel) return pin_log[c][j - int'(SS)];
    return 1'b0;
  endfunction

  function automatic int win_on(input int c, input int a, input int b);
    int s = 0;
    for (int k = a; k < b; k++) s += int'(on_at(c, k));
    return s;
  endfunction

  initial begin
    exp_t e;
    bit   on, edg;
    int   el;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        rel = cyc + 1;
        for (int c = 0; c < 3; c++) begin
          m_meas[c]  = 1'b0;
          m_stuck[c] = 1'b0;
          m_ref[c]   = cyc + 1;
        end
        exp_q.delete();
      end else begin
        for (int c = 0; c < 3; c++) begin
          pin_log[c][cyc] = AL ? !pwm_n[c] : pwm_n[c];
          on  = on_at(c, cyc);
          edg = on && !on_at(c, cyc - 1);
          el  = cyc - m_ref[c];
          if (m_stuck[c]) begin
            if (edg) begin
              m_stuck[c] = 1'b0;
              m_meas[c]  = 1'b1;
              m_ref[c]   = cyc;
            end
          end else if (edg) begin
            if (m_meas[c]) begin
              e.cyc = cyc; e.ch = c; e.per = el; e.ont = win_on(c, m_ref[c], cyc);
              e.stk = 1'b0; e.lvl = 1'b0;
              exp_q.push_back(e);
            end
            m_meas[c] = 1'b1;
            m_ref[c]  = cyc;
          end else if (el == int'(MAXP)) begin
            e.cyc = cyc; e.ch = c; e.per = MAXP; e.ont = on ? MAXP : 0;
            e.stk = 1'b1; e.lvl = on;
            exp_q.push_back(e);
            m_stuck[c] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int pulses[3];
  int last_cyc[3], last_per[3], last_ont[3], last_stk[3], last_lvl[3];

  initial begin
    exp_t e;
    for (int c = 0; c < 3; c++) pulses[c] = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          fail_now("missed_report", exp_q[0].ch);
          void'(exp_q.pop_front());
        end
        for (int c = 0; c < 3; c++) begin
          if (valid[c]) begin
            pulses[c]++;
            last_cyc[c] = cyc;
            last_per[c] = int'(period[c*CW +: CW]);
            last_ont[c] = int'(on_time[c*CW +: CW]);
            last_stk[c] = int'(stuck[c]);
            last_lvl[c] = int'(stuck_level[c]);
          end
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ch == c) begin
            e = exp_q.pop_front();
            chk("valid_present", int'(valid[c]), 1);
            if (valid[c]) begin
              chk("period", int'(period[c*CW +: CW]), e.per);
              chk("on_time", int'(on_time[c*CW +: CW]), e.ont);
              chk("stuck", int'(stuck[c]), int'(e.stk));
              if (e.stk) chk("stuck_level", int'(stuck_level[c]), int'(e.lvl));
            end
          end else if (valid[c]) begin
            fail_now("unexpected_valid", c);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int g_mode[3], g_p[3], g_d[3], g_t[3], fall_cyc[3], snap[3];
  bit g_hold[3], g_on[3];

  task automatic set_pwm(input int c, input int p, input int d);
    g_mode[c] = 1; g_p[c] = p; g_d[c] = d; g_t[c] = 0;
  endtask

  task automatic set_hold(input int c, input bit o);
    g_mode[c] = 0; g_hold[c] = o;
  endtask

  task automatic run(input int n);
    bit o;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (g_mode[c] == 0) o = g_hold[c];
        else begin
          o = (g_t[c] < g_d[c]);
          g_t[c] = (g_t[c] + 1) % g_p[c];
        end
        if (o && !g_on[c]) fall_cyc[c] = cyc;
        g_on[c]  = o;
        pwm_n[c] = AL ? !o : o;
      end
    end
  endtask

  task automatic take_snap();
    for (int c = 0; c < 3; c++) snap[c] = pulses[c];
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'(valid == 0 && stuck == 0 && stuck_level == 0 && period == 0 && on_time == 0), 1);
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      set_hold(c, 1'b0);
      g_on[c] = 1'b0;
      fall_cyc[c] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset_outputs");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle lines: one stuck-off timeout per channel, MAXP edges after release.
    take_snap();
    run(9000);
    for (int c = 0; c < 3; c++) begin
      chk("idle_pulse_count", pulses[c] - snap[c], 1);
      chk("idle_stuck", last_stk[c], 1);
      chk("idle_level", last_lvl[c], 0);
      chk("idle_on_time", last_ont[c], 0);
      chk("idle_time", last_cyc[c] - rel, MAXP);
    end

    // Driver-style PWM on R.
    take_snap();
    set_pwm(0, 5001, 1000);
    run(2 * 5001 + 10);
    chk("r_pulse_count", pulses[0] - snap[0], 2);
    chk("r_period", last_per[0], 5001);
    chk("r_on_time", last_ont[0], 1000);
    chk("r_stuck", last_stk[0], 0);
    chk("r_latency", last_cyc[0] - fall_cyc[0], SS + 1);

    // G held on after one edge.
    set_hold(0, 1'b0);
    set_hold(1, 1'b1);
    take_snap();
    run(8201);
    chk("g_hold_count", pulses[1] - snap[1], 1);
    chk("g_hold_stuck", last_stk[1], 1);
    chk("g_hold_level", last_lvl[1], 1);
    chk("g_hold_on_time", last_ont[1], MAXP);
    chk("g_hold_period", last_per[1], MAXP);
    chk("g_hold_latency", last_cyc[1] - fall_cyc[1], MAXP + SS + 1);
    take_snap();
    run(1000);
    chk("g_no_more_pulses", pulses[1] - snap[1], 0);
    take_snap();
    set_pwm(1, 3000, 1000);
    run(3 * 3000 + 10);
    chk("g_resume_count", pulses[1] - snap[1], 2);
    chk("g_resume_period", last_per[1], 3000);
    chk("g_resume_on_time", last_ont[1], 1000);
    chk("g_resume_stuck", last_stk[1], 0);

    // Identical PWM on all three, duties 0 / 2500 / 5000.
    take_snap();
    set_pwm(0, 5001, 0);
    set_pwm(1, 5001, 2500);
    set_pwm(2, 5001, 5000);
    run(2 * 5001 + 10);
    chk("r_off_count", pulses[0] - snap[0], 0);
    chk("r_off_stuck", int'(stuck[0]), 1);
    chk("r_off_level", int'(stuck_level[0]), 0);
    chk("r_off_on_time", int'(on_time[CW-1:0]), 0);
    chk("g_half_period", last_per[1], 5001);
    chk("g_half_on_time", last_ont[1], 2500);
    chk("b_full_count", pulses[2] - snap[2], 2);
    chk("b_full_period", last_per[2], 5001);
    chk("b_full_on_time", last_ont[2], 5000);
    chk("gb_same_cycle", last_cyc[2], last_cyc[1]);

    // Period exactly MAXP: the edge beats the timeout.
    take_snap();
    set_pwm(0, MAXP, 100);
    run(2 * MAXP + 10);
    chk("r_max_count", pulses[0] - snap[0], 2);
    chk("r_max_period", last_per[0], MAXP);
    chk("r_max_stuck", last_stk[0], 0);
    chk("r_max_on_time", last_ont[0], 100);

    // Reset mid-period.
    run(1000);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset_immediate");
    set_hold(0, 1'b0);
    run(3);
    #1 chk_all_zero("midreset_held");
    rst_n = 1'b1;
    take_snap();
    set_pwm(0, 4000, 1234);
    run(4005);
    chk("post_reset_count", pulses[0] - snap[0], 1);
    chk("post_reset_period", last_per[0], 4000);
    chk("post_reset_on_time", last_ont[0], 1234);

    // Random PWM segments.
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        int p, d;
        p = int'($urandom_range(3, 1500));
        d = int'($urandom_range(0, p));
        set_pwm(c, p, d);
        g_t[c] = int'($urandom_range(0, p - 1));
      end
      run(int'($urandom_range(2000, 4000)));
    end

    run(20);
    #2 chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
